// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, default width,
// and the funct-to-op decode used by the instruction decoder.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NOP   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    // R-type funct field to unit op; anything else is a no-op for this unit
    function automatic md_op_e md_decode(input logic [5:0] funct);
        case (funct)
            6'h11:   return MD_MTHI;
            6'h13:   return MD_MTLO;
            6'h18:   return MD_MULT;
            6'h19:   return MD_MULTU;
            6'h1A:   return MD_DIV;
            6'h1B:   return MD_DIVU;
            default: return MD_NOP;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the decode stage and the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = muldiv_pkg::MD_WIDTH);
    import muldiv_pkg::*;

    logic             Start;
    md_op_e           Op;
    logic [WIDTH-1:0] Rdata1;
    logic [WIDTH-1:0] Rdata2;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (output Start, Op, Rdata1, Rdata2,
                    input  Busy, Done, DivZero, Hi, Lo);
    modport slave  (input  Start, Op, Rdata1, Rdata2,
                    output Busy, Done, DivZero, Hi, Lo);
endinterface

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result fixup.
module muldiv_negate #(parameter int W = 32) (
    input  logic         en,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);
    assign y = en ? ((~a) + W'(1)) : a;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiply / restoring divide with HI/LO registers.
// Define MULDIV_SIGNED_EN for signed MULT/DIV; otherwise they behave as MULTU/DIVU.
//
// state | meaning
// IDLE  | waiting for Start; MTHI/MTLO write Hi/Lo directly
// CALC  | one multiplier/quotient bit per cycle, WIDTH cycles
// FIX   | sign fixup, write Hi/Lo, pulse Done
module muldiv_unit import muldiv_pkg::*; #(parameter int WIDTH = MD_WIDTH) (
    input logic     CLK,
    input logic     RST,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    md_state_e        state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opb;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             is_div, div_zero, done_q, div_zero_q;
    logic             is_mdop, issue, last;
    logic [WIDTH-1:0] opa_mag, opb_mag, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;

    assign is_mdop = (bus.Op == MD_MULT) || (bus.Op == MD_MULTU) ||
                     (bus.Op == MD_DIV)  || (bus.Op == MD_DIVU);
    assign issue   = bus.Start && (state == IDLE) && is_mdop;
    assign last    = (cnt == CW'(WIDTH - 1));

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opb};

`ifdef MULDIV_SIGNED_EN
    logic signed_op, neg_a_nxt, neg_b_nxt, neg_a, neg_b;

    assign signed_op = (bus.Op == MD_MULT) || (bus.Op == MD_DIV);
    assign neg_a_nxt = signed_op & bus.Rdata1[WIDTH-1];
    assign neg_b_nxt = signed_op & bus.Rdata2[WIDTH-1];

    muldiv_negate #(.W(WIDTH)) u_neg_a (.en(neg_a_nxt), .a(bus.Rdata1), .y(opa_mag));
    muldiv_negate #(.W(WIDTH)) u_neg_b (.en(neg_b_nxt), .a(bus.Rdata2), .y(opb_mag));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            neg_a <= 1'b0;
            neg_b <= 1'b0;
        end else if (issue) begin
            neg_a <= neg_a_nxt;
            neg_b <= neg_b_nxt;
        end
    end

    muldiv_negate #(.W(2*WIDTH)) u_fix_prod (.en(neg_a ^ neg_b), .a({acc_hi, acc_lo}), .y(prod_fix));
    muldiv_negate #(.W(WIDTH))   u_fix_quo  (.en(neg_a ^ neg_b), .a(acc_lo), .y(quo_fix));
    // remainder follows the dividend sign; with a zero divisor this restores Rdata1 exactly
    muldiv_negate #(.W(WIDTH))   u_fix_rem  (.en(neg_a), .a(acc_hi), .y(rem_fix));
`else
    assign opa_mag  = bus.Rdata1;
    assign opb_mag  = bus.Rdata2;
    assign prod_fix = {acc_hi, acc_lo};
    assign quo_fix  = acc_lo;
    assign rem_fix  = acc_hi;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = CALC;
            CALC:    if (last)  state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt        <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            opb        <= '0;
            is_div     <= 1'b0;
            div_zero   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        cnt      <= '0;
                        acc_hi   <= '0;
                        acc_lo   <= opa_mag;
                        opb      <= opb_mag;
                        is_div   <= (bus.Op == MD_DIV) || (bus.Op == MD_DIVU);
                        div_zero <= (bus.Rdata2 == '0);
                    end else if (bus.Start && bus.Op == MD_MTHI) begin
                        hi_q <= bus.Rdata1;
                    end else if (bus.Start && bus.Op == MD_MTLO) begin
                        lo_q <= bus.Rdata1;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        if (!div_trial[WIDTH]) begin
                            acc_hi <= div_trial[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done_q     <= 1'b1;
                    div_zero_q <= is_div & div_zero;
                    if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= div_zero ? '1 : quo_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy    = (state != IDLE);
    assign bus.Done    = done_q;
    assign bus.DivZero = div_zero_q;
    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;

endmodule
